// File: rtl/enc_sample_sched.sv
// enc_sample_sched
//   Runs the per-wheel encoder counters on a fixed sample period and hands
//   each period's counts to the host. Every period it clears the counters,
//   lets them settle, enables counting for PERIOD_CYC cycles, and then
//   snapshots every channel in a single cycle. The snapshot set goes to the
//   host through a valid/ack handshake, and the host reads it back one
//   channel at a time.
//
// Ports
//   clk         system clock; all logic runs on the rising edge
//   rst         synchronous reset, active-high
//   en          sampling enable (level); dropping it abandons the period
//   cnt_dout    channel counts, channel k = cnt_dout[k*DW +: DW]
//   cnt_start   count enable to all counters (registered)
//   cnt_clr_n   counter clear, active-low (registered)
//   snap_valid  a new snapshot set is available
//   snap_ack    host has consumed the snapshot (1-cycle pulse)
//   rd_sel      channel select for readback
//   rd_data     registered snapshot[rd_sel], zero for out-of-range selects
//   sample_id   number of completed captures, wraps at 16 bits
//   overrun     sticky flag: a snapshot was overwritten before it was acked
module enc_sample_sched #(
  parameter int NUM_CH     = 4,
  parameter int DW         = 32,
  parameter int PERIOD_CYC = 1000000,
  parameter int CLR_CYC    = 2,
  parameter int SETTLE_CYC = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        en,
  input  logic [NUM_CH*DW-1:0]                        cnt_dout,
  output logic                                        cnt_start,
  output logic                                        cnt_clr_n,
  output logic                                        snap_valid,
  input  logic                                        snap_ack,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] rd_sel,
  output logic [DW-1:0]                               rd_data,
  output logic [15:0]                                 sample_id,
  output logic                                        overrun
);

  // The shared timer must hold the longest phase length minus one.
  localparam int TMAX = (PERIOD_CYC > CLR_CYC)
                        ? ((PERIOD_CYC > SETTLE_CYC) ? PERIOD_CYC : SETTLE_CYC)
                        : ((CLR_CYC > SETTLE_CYC) ? CLR_CYC : SETTLE_CYC);
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SETTLE,
    RUN,
    CAPTURE
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [TW-1:0]   timer;
  logic [TW-1:0]   next_timer;
  logic            capture;
  logic [DW-1:0]   snapshot [NUM_CH];

  assign capture = (state == CAPTURE);

  // Next-state logic. The timer is reloaded with (phase length - 1) when a
  // phase is entered and counts down to zero, so every timed phase lasts
  // exactly its configured number of cycles. Dropping en leaves any active
  // phase straight away; CAPTURE is the exception because its capture has
  // already happened in that cycle.
  always_comb begin
    next_state = state;
    next_timer = timer;
    case (state)
      IDLE: begin
        if (en) begin
          next_state = CLEAR;
          next_timer = TW'(CLR_CYC - 1);
        end
      end
      CLEAR: begin
        if (!en) begin
          next_state = IDLE;
          next_timer = '0;
        end else if (timer == '0) begin
          next_state = SETTLE;
          next_timer = TW'(SETTLE_CYC - 1);
        end else begin
          next_timer = timer - 1'b1;
        end
      end
      SETTLE: begin
        if (!en) begin
          next_state = IDLE;
          next_timer = '0;
        end else if (timer == '0) begin
          next_state = RUN;
          next_timer = TW'(PERIOD_CYC - 1);
        end else begin
          next_timer = timer - 1'b1;
        end
      end
      RUN: begin
        if (!en) begin
          next_state = IDLE;
          next_timer = '0;
        end else if (timer == '0) begin
          next_state = CAPTURE;
          next_timer = '0;
        end else begin
          next_timer = timer - 1'b1;
        end
      end
      CAPTURE: begin
        if (en) begin
          next_state = CLEAR;
          next_timer = TW'(CLR_CYC - 1);
        end else begin
          next_state = IDLE;
          next_timer = '0;
        end
      end
      default: begin
        next_state = IDLE;
        next_timer = '0;
      end
    endcase
  end

  // State register. Counter controls are registered from the state being
  // entered, so they line up with the state on the same cycle and stay
  // glitch-free on their way to the counter instances.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      cnt_start <= 1'b0;
      cnt_clr_n <= 1'b1;
    end else begin
      state     <= next_state;
      timer     <= next_timer;
      cnt_start <= (next_state == RUN) || (next_state == CAPTURE);
      cnt_clr_n <= (next_state != CLEAR);
    end
  end

  // All channels are snapshotted on the same edge, so the set is coherent.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        snapshot[k] <= '0;
      end
    end else if (capture) begin
      for (int k = 0; k < NUM_CH; k++) begin
        snapshot[k] <= cnt_dout[k*DW +: DW];
      end
    end
  end

  // Host handshake. A capture has priority over an ack in the same cycle,
  // because the ack refers to the older data and the new set is still unread.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_valid <= 1'b0;
      sample_id  <= '0;
      overrun    <= 1'b0;
    end else if (capture) begin
      snap_valid <= 1'b1;
      sample_id  <= sample_id + 16'd1;
      if (snap_valid && !snap_ack) begin
        overrun <= 1'b1;
      end
    end else if (snap_ack && snap_valid) begin
      snap_valid <= 1'b0;
    end
  end

  // Registered readback with zero for selects beyond the channel count.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (int'(rd_sel) < NUM_CH) begin
      rd_data <= snapshot[rd_sel];
    end else begin
      rd_data <= '0;
    end
  end

endmodule
